shared_port_arbiter: RTL and testbench
======================================

Name: shared_port_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one multi-cycle 32-bit resource among four requesters, such as a memory port or a multi-cycle ALU unit.
- Drives the 2-bit select of the 4:1 32-bit datapath mux in front of the resource, issues a one-cycle Start strobe, and holds the grant until the resource returns Done or a timeout fires.
- Sits between the requesting pipeline/DMA blocks and the shared resource.

Parameters:
- TIMEOUT_CYCLES, 255: WAIT cycles before a forced release. 0 disables the timeout. Legal range 0..65535.
- RESET_PTR, 0: round-robin pointer value after reset. Legal range 0..3.

Ports:
- Clk  input  1  single clock; all state changes on the rising edge.
- Rst  input  1  asynchronous, active-low reset.
- Req  input  4  per-requester request level; bit i = requester i.
- Done  input  1  resource completion pulse, 1 cycle.
- Grant  output  4  one-hot grant, or all zeros.
- Src  output  2  mux select = index of the granted requester.
- Start  output  1  1-cycle strobe telling the resource to begin.
- Busy  output  1  high whenever not in IDLE.
- Timeout  output  1  1-cycle pulse on a forced release.

Behaviour:
- Clocking/reset:
  - One clock domain.
  - Rst low asynchronously clears everything: Grant=0, Src=0, Start=0, Busy=0, Timeout=0, Ptr=RESET_PTR, counter=0, state=IDLE.
  - Rst asserted mid-transaction aborts it with no Timeout pulse. The resource is reset by the same Rst.
- All outputs are registered; no combinational path from Req or Done to any output.
- States:
  - IDLE: Grant=0, Busy=0. If Req!=0, pick the winner W = first set bit of Req, searching from Ptr upward modulo 4. Next edge: Grant=1<<W, Src=W, Start=1, Busy=1, state=START.
  - START: lasts one cycle, Start=1. Next edge: Start=0, state=WAIT, counter=0. Done in START is ignored; the resource cannot finish in the start cycle.
  - WAIT: Grant and Src held stable. Counter increments each cycle, saturating at 16 bits.
    - Done=1: next edge Grant=0, Ptr=(W+1) mod 4, state=IDLE.
    - Else, if TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1: next edge Timeout=1 for one cycle, Grant=0, Ptr=(W+1) mod 4, state=IDLE.
    - Done and timeout on the same cycle: treated as Done; no Timeout pulse.
- Src keeps its last value in IDLE; it only changes on a new grant.
- Latency:
  - Req rising in IDLE at edge n → Grant/Start visible after edge n+1.
  - Minimum occupancy: START 1 cycle + WAIT ≥1 cycle.
  - Re-arbitration costs one IDLE cycle.
- Req dropped while granted: the grant is held until Done or timeout; a committed transaction is never cancelled.
- Req bits changing in START/WAIT have no effect until IDLE.
- Fairness: a requester continuously asserting Req waits at most 3 other transactions.
- Ptr wraps 3 → 0.
- Grant is never multi-hot. Src always equals the index of the set Grant bit while Grant!=0.

Optional Feature:
- Macro: ARB_BACK2BACK_EN.
- Defined: on a Done or timeout release, if any Req bit is set, skip IDLE. Arbitrate immediately using the updated pointer (W+1) and go straight to START. The next edge loads the new Grant/Src with Start=1 and Busy held high, saving one cycle per transaction.
- Undefined: always return to IDLE for one cycle, Busy=0 in that cycle, as described above.

Test Plan:
- Reset with Req=0110: while Rst low, Grant=0, Start=0, Busy=0. After release with Ptr=0: Grant=0010, Src=1, Start high for exactly 1 cycle.
- All Req=1111 held, Done 3 cycles after each Start: grant order 0,1,2,3,0. Src follows 0,1,2,3,0. Without ARB_BACK2BACK_EN there is one idle cycle between grants; with it, zero.
- Grant 2 active, Req[2] dropped in WAIT, Done after 5 cycles: Grant stays 0100 until Done, then returns to 0. Next winner searched from 3.
- TIMEOUT_CYCLES=4, Done never asserted: Timeout pulses exactly once, 4 cycles after entering WAIT. Grant clears and Ptr advances.
- Done and the timeout condition coincide (TIMEOUT_CYCLES=4, Done on 4th WAIT cycle): release occurs, Timeout stays 0.
- Rst pulsed low mid-WAIT with Grant=1000: Grant, Start and Busy clear immediately, without waiting for a clock edge. After release, Ptr=RESET_PTR.

Source files
------------

// File: rtl/shared_port_arbiter.sv
// shared_port_arbiter
//   Round-robin arbiter/sequencer sharing one multi-cycle 32-bit resource
//   among four requesters. Drives the 4:1 datapath mux select, issues a
//   one-cycle start strobe, and holds the grant until done or timeout.
//
// Ports
//   clk      in   single clock, rising edge
//   rst      in   asynchronous active-low reset
//   req[3:0] in   per-requester request level
//   done     in   resource completion pulse
//   grant    out  one-hot grant or zero
//   src      out  mux select, index of granted requester (held in idle)
//   start    out  one-cycle begin strobe to the resource
//   busy     out  high whenever not idle
//   timeout  out  one-cycle pulse on forced release
//
// Parameters
//   TIMEOUT_CYCLES  wait cycles before forced release, 0 disables
//   RESET_PTR       round-robin pointer after reset
//
// Build option
//   ARB_BACK2BACK_EN  when defined, a release with any request pending
//                     re-arbitrates immediately and skips the idle cycle.

module shared_port_arbiter #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int RESET_PTR      = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] grant,
  output logic [1:0] src,
  output logic       start,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} state_t;

  localparam logic [1:0]  PTR_RST = 2'(RESET_PTR);
  localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] TO_LAST = 16'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);

  state_t      state;
  logic [1:0]  ptr;
  logic [15:0] cnt;

  // {found, index}: first set request bit searching upward from p, mod 4.
  // Scanning from the far end lets the nearest hit overwrite the rest.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  logic [2:0] pick_idle;
  logic       wait_to;

  assign pick_idle = rr_pick(req, ptr);
  assign wait_to   = TO_EN && (cnt == TO_LAST);

`ifdef ARB_BACK2BACK_EN
  // While in WAIT, src is the current winner, so src+1 is the pointer the
  // release is about to install.
  logic [2:0] pick_rel;
  assign pick_rel = rr_pick(req, 2'(src + 2'd1));
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      grant   <= '0;
      src     <= '0;
      start   <= 1'b0;
      busy    <= 1'b0;
      timeout <= 1'b0;
      ptr     <= PTR_RST;
      cnt     <= '0;
    end else begin
      start   <= 1'b0;
      timeout <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pick_idle[2]) begin
            grant <= 4'b0001 << pick_idle[1:0];
            src   <= pick_idle[1:0];
            start <= 1'b1;
            busy  <= 1'b1;
            state <= S_START;
          end
        end
        // Resource cannot finish in its start cycle; done is ignored here.
        S_START: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (done || wait_to) begin
            // Coincident done and timeout counts as a normal completion.
            timeout <= !done;
            ptr     <= 2'(src + 2'd1);
`ifdef ARB_BACK2BACK_EN
            if (pick_rel[2]) begin
              grant <= 4'b0001 << pick_rel[1:0];
              src   <= pick_rel[1:0];
              start <= 1'b1;
              state <= S_START;
            end else begin
              grant <= '0;
              busy  <= 1'b0;
              state <= S_IDLE;
            end
`else
            grant <= '0;
            busy  <= 1'b0;
            state <= S_IDLE;
`endif
          end else if (cnt != 16'hFFFF) begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin
          grant <= '0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shared_port_arbiter.sv
module tb_shared_port_arbiter;

  localparam int T      = 4;
  localparam int RPTR   = 0;
  localparam int NCYC   = 3000;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic [1:0] src;
  logic       start, busy, timeout;

  int n_tot = 0;
  int n_bad = 0;

  shared_port_arbiter #(.TIMEOUT_CYCLES(T), .RESET_PTR(RPTR)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .grant(grant), .src(src), .start(start), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Transaction-level reference: who owns the resource and how many cycles
  // since its grant appeared (0 = start cycle, k = k-th wait cycle).
  int         own;
  int         age;
  int         m_ptr;
  int         m_src;
  bit         m_tout;

`ifdef ARB_BACK2BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++)
      if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  task automatic m_reset();
    own = -1; age = 0; m_ptr = RPTR; m_src = 0; m_tout = 1'b0;
  endtask

  task automatic m_grant(input int p);
    own = pick(req, p); m_src = own; age = 0;
  endtask

  // Advance the reference by one rising edge using the inputs now applied.
  task automatic m_step();
    m_tout = 1'b0;
    if (own < 0) begin
      if (req != 4'b0) m_grant(m_ptr);
    end else if (age == 0) begin
      age = 1;
    end else if (done || (T != 0 && age == T)) begin
      m_tout = !done;
      m_ptr  = (own + 1) % 4;
      own    = -1;
      if (B2B && req != 4'b0) m_grant(m_ptr);
    end else begin
      age++;
    end
  endtask

  task automatic check_all();
    logic [3:0] eg;
    eg = (own >= 0) ? (4'b0001 << own) : 4'b0000;
    chk("grant",   32'(grant),   32'(eg));
    chk("src",     32'(src),     32'(m_src));
    chk("start",   32'(start),   32'(own >= 0 && age == 0));
    chk("busy",    32'(busy),    32'(own >= 0));
    chk("timeout", 32'(timeout), 32'(m_tout));
    chk("onehot",  32'($onehot0(grant)), 32'd1);
    if (grant != 4'b0) chk("src_vs_grant", 32'(grant[src]), 32'd1);
  endtask

  initial begin
    int mode;
    rst  = 1'b0;
    req  = 4'b0110;
    done = 1'b0;
    mode = 0;
    m_reset();
    repeat (3) begin
      @(negedge clk);
      check_all();
    end
    rst = 1'b1;
    m_step();

    for (int i = 0; i < NCYC; i++) begin
      @(negedge clk);
      check_all();
      if (!rst) begin
        rst = 1'b1;
      end else if (i > 20 && $urandom_range(0, 149) == 0) begin
        // Asynchronous clear between edges.
        rst = 1'b0;
        #1;
        chk("async_grant", 32'(grant), 32'd0);
        chk("async_start", 32'(start), 32'd0);
        chk("async_busy",  32'(busy),  32'd0);
        m_reset();
        continue;
      end
      if (i % 50 == 0) mode = $urandom_range(0, 2);
      // First cycles keep req=0110 so the post-reset winner is requester 1.
      if (i >= 2) begin
        case (mode)
          0:       req = 4'($urandom);
          1:       req = 4'b1111;
          default: req = ($urandom_range(0, 3) == 0) ? 4'($urandom) : req;
        endcase
      end
      done = ($urandom_range(0, 3) == 0);
      m_step();
    end

    @(negedge clk);
    check_all();
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
